bel_avl_mst: RTL and testbench

Avalon-MM initiator (master) that moves a block of FFT samples between a word-addressed Avalon memory and a local valid/ready stream. It is the counterpart of the FFT data RAM responder: it drives address/read/write and consumes readdata/readdatavalid. It sits between the FFT core's sample streams and the shared sample RAM.

---
 rtl/bel_avl_mst_pkg.sv | 29 ++
 rtl/bel_avl_mst_fifo.sv | 60 ++++++
 rtl/bel_avl_mst.sv | 178 +++++++++++++++++
 tb/tb_bel_avl_mst.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bel_avl_mst_pkg.sv
// bel_avl_mst_pkg: shared sample width and state encodings for the Avalon-MM sample mover.
// Revision: 1.0
`default_nettype none

`ifndef BEL_FFT_DWIDTH
`define BEL_FFT_DWIDTH 16
`endif

package bel_avl_mst_pkg;

  localparam int DWIDTH = `BEL_FFT_DWIDTH;

  localparam logic [2:0] ST_IDLE_ENC     = 3'd0;
  localparam logic [2:0] ST_RD_ENC       = 3'd1;
  localparam logic [2:0] ST_RD_DRAIN_ENC = 3'd2;
  localparam logic [2:0] ST_WR_ENC       = 3'd3;
  localparam logic [2:0] ST_DONE_ENC     = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE     = ST_IDLE_ENC,
    ST_RD       = ST_RD_ENC,
    ST_RD_DRAIN = ST_RD_DRAIN_ENC,
    ST_WR       = ST_WR_ENC,
    ST_DONE     = ST_DONE_ENC
  } state_t;

endpackage

`default_nettype wire

// File: rtl/bel_avl_mst_fifo.sv
// bel_avl_mst_fifo: synchronous read-return FIFO with simultaneous push/pop and count.
// Revision: 1.0
`default_nettype none

module bel_avl_mst_fifo #(
  parameter int FIFO_DEPTH = 4,
  parameter int DATA_WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  logic [DATA_WIDTH-1:0]         push_data,
  input  logic                          pop,
  output logic [DATA_WIDTH-1:0]         head,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          empty
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW-1:0] PTR_ONE = 1;
  localparam logic [PW:0]   CNT_ONE = 1;
  localparam logic [PW:0]   CNT_MAX = (PW+1)'(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  // A push into a full FIFO is only legal when a pop frees the slot this cycle.
  assign do_push = push & ((count != CNT_MAX) | do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/bel_avl_mst.sv
// bel_avl_mst: Avalon-MM initiator moving a block of samples between memory and a valid/ready stream.
// Optional BEL_AVL_MST_BITREV_EN adds cmd_bitrev for bit-reversed addressing. Revision: 1.0
`default_nettype none

`ifndef BEL_FFT_DWIDTH
`define BEL_FFT_DWIDTH 16
`endif

module bel_avl_mst
  import bel_avl_mst_pkg::*;
#(
  parameter int ADR_WIDTH  = 6,
  parameter int LEN_WIDTH  = 7,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       cmd_start,
  input  logic                       cmd_write,
  input  logic [ADR_WIDTH-1:0]       cmd_adr,
  input  logic [LEN_WIDTH-1:0]       cmd_len,
`ifdef BEL_AVL_MST_BITREV_EN
  input  logic                       cmd_bitrev,
`endif
  output logic                       busy,
  output logic                       done,
  output logic [ADR_WIDTH-1:0]       address,
  output logic                       read,
  output logic                       write,
  output logic [`BEL_FFT_DWIDTH-1:0] writedata,
  input  logic                       waitrequest,
  input  logic [`BEL_FFT_DWIDTH-1:0] readdata,
  input  logic                       readdatavalid,
  output logic [`BEL_FFT_DWIDTH-1:0] so_data,
  output logic                       so_valid,
  input  logic                       so_ready,
  input  logic [`BEL_FFT_DWIDTH-1:0] si_data,
  input  logic                       si_valid,
  output logic                       si_ready
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [LEN_WIDTH-1:0] LEN_ONE   = 1;
  localparam logic [CW-1:0]        OUT_ONE   = 1;
  localparam logic [CW:0]          CREDIT_CAP = (CW+1)'(FIFO_DEPTH);

  state_t                 state;
  state_t                 state_nxt;
  logic [ADR_WIDTH-1:0]   base;
  logic [LEN_WIDTH-1:0]   len;
  logic [LEN_WIDTH-1:0]   issued;
  logic [CW-1:0]          outstanding;
  logic [CW-1:0]          fifo_count;
  logic                   fifo_empty;
  logic                   push;
  logic                   pop;
  logic                   rd_acc;
  logic                   wr_acc;
  logic                   more;
  logic [CW:0]            credit_used;
  logic [ADR_WIDTH-1:0]   lin_off;
  logic [ADR_WIDTH-1:0]   offset;

  generate
    if (LEN_WIDTH >= ADR_WIDTH) begin : g_off_trunc
      assign lin_off = issued[ADR_WIDTH-1:0];
    end else begin : g_off_ext
      assign lin_off = {{(ADR_WIDTH-LEN_WIDTH){1'b0}}, issued};
    end
  endgenerate

`ifdef BEL_AVL_MST_BITREV_EN
  logic                 bitrev;
  logic [ADR_WIDTH-1:0] rev_off;

  always_comb begin
    rev_off = '0;
    for (int i = 0; i < ADR_WIDTH; i++) begin
      rev_off[i] = lin_off[ADR_WIDTH-1-i];
    end
  end

  assign offset = bitrev ? rev_off : lin_off;
`else
  assign offset = lin_off;
`endif

  assign address = base + offset;
  assign more    = (issued < len);

  // Reads are credited against free FIFO slots so returns can never overflow it.
  assign credit_used = {1'b0, fifo_count} + {1'b0, outstanding};
  assign read        = (state == ST_RD) & more & (credit_used < CREDIT_CAP);
  assign rd_acc      = read & ~waitrequest;

  assign push     = readdatavalid & ((state == ST_RD) | (state == ST_RD_DRAIN));
  assign so_valid = ~fifo_empty;
  assign pop      = so_valid & so_ready;

  assign write     = (state == ST_WR) & si_valid & more;
  assign writedata = si_data;
  assign si_ready  = (state == ST_WR) & ~waitrequest & more;
  assign wr_acc    = si_valid & si_ready;

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);

  bel_avl_mst_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .DATA_WIDTH (`BEL_FFT_DWIDTH)
  ) u_fifo (
    .clk       (clk_i),
    .rst       (rst_i),
    .push      (push),
    .push_data (readdata),
    .pop       (pop),
    .head      (so_data),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (cmd_start) begin
          if (cmd_len == '0)   state_nxt = ST_DONE;
          else if (cmd_write)  state_nxt = ST_WR;
          else                 state_nxt = ST_RD;
        end
      end
      ST_RD: begin
        if (issued == len) state_nxt = ST_RD_DRAIN;
      end
      ST_RD_DRAIN: begin
        if ((outstanding == '0) && fifo_empty && !push) state_nxt = ST_DONE;
      end
      ST_WR: begin
        if (wr_acc && ((issued + LEN_ONE) == len)) state_nxt = ST_DONE;
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= ST_IDLE;
      base        <= '0;
      len         <= '0;
      issued      <= '0;
      outstanding <= '0;
`ifdef BEL_AVL_MST_BITREV_EN
      bitrev      <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      if ((state == ST_IDLE) && cmd_start) begin
        base   <= cmd_adr;
        len    <= cmd_len;
        issued <= '0;
`ifdef BEL_AVL_MST_BITREV_EN
        bitrev <= cmd_bitrev;
`endif
      end else if (rd_acc || wr_acc) begin
        issued <= issued + LEN_ONE;
      end
      case ({rd_acc, push})
        2'b10:   outstanding <= outstanding + OUT_ONE;
        2'b01:   outstanding <= outstanding - OUT_ONE;
        default: outstanding <= outstanding;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bel_avl_mst.sv
// tb_bel_avl_mst: directed self-checking bench with a variable-latency Avalon memory model.
// Revision: 1.0
`default_nettype none

module tb_bel_avl_mst;
  import bel_avl_mst_pkg::*;

  localparam int AW = 6;
  localparam int LW = 7;
  localparam int DW = DWIDTH;

  logic          clk;
  logic          rst_i;
  logic          cmd_start;
  logic          cmd_write;
  logic [AW-1:0] cmd_adr;
  logic [LW-1:0] cmd_len;
`ifdef BEL_AVL_MST_BITREV_EN
  logic          cmd_bitrev;
`endif
  logic          busy;
  logic          done;
  logic [AW-1:0] address;
  logic          read;
  logic          write;
  logic [DW-1:0] writedata;
  logic          waitrequest;
  logic [DW-1:0] readdata;
  logic          readdatavalid;
  logic [DW-1:0] so_data;
  logic          so_valid;
  logic          so_ready;
  logic [DW-1:0] si_data;
  logic          si_valid;
  logic          si_ready;

  int total = 0;
  int bad   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  bel_avl_mst dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .cmd_start     (cmd_start),
    .cmd_write     (cmd_write),
    .cmd_adr       (cmd_adr),
    .cmd_len       (cmd_len),
`ifdef BEL_AVL_MST_BITREV_EN
    .cmd_bitrev    (cmd_bitrev),
`endif
    .busy          (busy),
    .done          (done),
    .address       (address),
    .read          (read),
    .write         (write),
    .writedata     (writedata),
    .waitrequest   (waitrequest),
    .readdata      (readdata),
    .readdatavalid (readdatavalid),
    .so_data       (so_data),
    .so_valid      (so_valid),
    .so_ready      (so_ready),
    .si_data       (si_data),
    .si_valid      (si_valid),
    .si_ready      (si_ready)
  );

  // Memory contents: 0x38..0x3F hold their own address, all others address+0x40.
  function automatic logic [DW-1:0] ram_init(int a);
    return (a >= 'h38) ? DW'(a) : DW'(a + 'h40);
  endfunction

  logic [DW-1:0] mem [64];
  int            lat = 1;
  logic [3:0]    pv;
  logic [DW-1:0] pd [4];
  int            cyc = 0;
  int            addr_n = 0, data_n = 0, wr_n = 0, wr_bad = 0, done_n = 0, busy_n = 0;
  int            wr_cyc = 0, done_cyc = 0;
  logic [AW-1:0] addr_log [512];
  int            addr_cyc [512];
  logic [DW-1:0] data_log [512];
  int            data_cyc [512];

  assign readdatavalid = pv[0];
  assign readdata      = pd[0];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    pv  <= {1'b0, pv[3:1]};
    for (int i = 0; i < 3; i++) pd[i] <= pd[i+1];
    if (rst_i) begin
      for (int i = 0; i < 64; i++) mem[i] <= ram_init(i);
    end else if (write && !waitrequest) begin
      mem[address] <= writedata;
      wr_n         <= wr_n + 1;
      wr_cyc       <= cyc;
    end
    if (write && !si_valid) wr_bad <= wr_bad + 1;
    if (read && !waitrequest) begin
      pv[lat-1]        <= 1'b1;
      pd[lat-1]        <= mem[address];
      addr_log[addr_n] <= address;
      addr_cyc[addr_n] <= cyc;
      addr_n           <= addr_n + 1;
    end
    if (so_valid && so_ready) begin
      data_log[data_n] <= so_data;
      data_cyc[data_n] <= cyc;
      data_n           <= data_n + 1;
    end
    if (done) begin
      done_n   <= done_n + 1;
      done_cyc <= cyc;
    end
    if (busy) busy_n <= busy_n + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic w, input logic [AW-1:0] a, input logic [LW-1:0] n);
    cmd_write = w;
    cmd_adr   = a;
    cmd_len   = n;
    cmd_start = 1'b1;
    tick();
    cmd_start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int dn0);
    int k;
    k = 0;
    while (done_n == dn0 && k < 400) begin
      tick();
      k++;
    end
    repeat (3) tick();
    check({tag, "_done"}, done_n - dn0, 1);
  endtask

  int a0, d0, dn0, w0, b0, d1, idx, wl, k;
  logic ph, acc;

  initial begin
    rst_i = 1'b1; cmd_start = 1'b0; cmd_write = 1'b0; cmd_adr = '0; cmd_len = '0;
`ifdef BEL_AVL_MST_BITREV_EN
    cmd_bitrev = 1'b0;
`endif
    waitrequest = 1'b0; so_ready = 1'b0; si_data = '0; si_valid = 1'b0; pv = '0;
    repeat (2) tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_read", read, 0);
    check("rst_write", write, 0);
    check("rst_addr", address, 0);
    check("rst_sovalid", so_valid, 0);
    check("rst_siready", si_ready, 0);
    rst_i = 1'b0;
    tick();

    // 8-word read near the top of memory, single-cycle slave
    so_ready = 1'b1;
    a0 = addr_n; d0 = data_n; dn0 = done_n;
    start(1'b0, 6'h38, 7'd8);
    wait_done("rd8", dn0);
    check("rd8_nreads", addr_n - a0, 8);
    for (int i = 0; i < 8; i++) begin
      check("rd8_adr", addr_log[a0+i], 'h38 + i);
      check("rd8_data", data_log[d0+i], 'h38 + i);
    end
    check("rd8_first_lat", data_cyc[d0] - addr_cyc[a0], 2);
    check("rd8_done_lat", done_cyc - data_cyc[d0+7], 2);

    // 10-word read wraps past 0x3F
    a0 = addr_n; d0 = data_n; dn0 = done_n;
    start(1'b0, 6'h38, 7'd10);
    wait_done("rd10", dn0);
    check("rd10_adr8", addr_log[a0+8], 'h00);
    check("rd10_adr9", addr_log[a0+9], 'h01);
    check("rd10_data8", data_log[d0+8], 'h40);
    check("rd10_data9", data_log[d0+9], 'h41);
    check("rd10_ndata", data_n - d0, 10);

    // 16-word read with back-pressure: only FIFO_DEPTH reads may be in flight
    so_ready = 1'b0;
    a0 = addr_n; d0 = data_n; dn0 = done_n;
    start(1'b0, 6'h00, 7'd16);
    repeat (20) tick();
    check("bp_reads", addr_n - a0, 4);
    check("bp_sovalid", so_valid, 1);
    so_ready = 1'b1;
    wait_done("bp", dn0);
    check("bp_ndata", data_n - d0, 16);
    for (int i = 0; i < 16; i++) check("bp_data", data_log[d0+i], 'h40 + i);

    // 5-word write, si_valid toggling, 2-cycle stall on the third word
    a0 = addr_n; w0 = wr_n; dn0 = done_n;
    start(1'b1, 6'h10, 7'd5);
    idx = 0; wl = 2; k = 0; ph = 1'b0;
    while (idx < 5 && k < 100) begin
      ph          = ~ph;
      si_valid    = ph;
      si_data     = DW'('hA0 + idx);
      waitrequest = (idx == 2) && (wl > 0) && (ph || wl == 1);
      if (waitrequest) wl--;
      @(negedge clk);
      acc = si_valid && si_ready;
      tick();
      if (acc) idx++;
      k++;
    end
    si_valid = 1'b0; waitrequest = 1'b0;
    check("wr_accepted", idx, 5);
    wait_done("wr", dn0);
    check("wr_count", wr_n - w0, 5);
    check("wr_novalid", wr_bad, 0);
    check("wr_done_lat", done_cyc - wr_cyc, 1);
    check("wr_noread", addr_n - a0, 0);
    for (int i = 0; i < 5; i++) check("wr_mem", mem['h10+i], 'hA0 + i);
    check("wr_mem_after", mem['h15], 'h55);

    // zero-length command
    a0 = addr_n; w0 = wr_n; dn0 = done_n; b0 = busy_n;
    start(1'b0, 6'h03, 7'd0);
    wait_done("len0", dn0);
    check("len0_busy", busy_n - b0, 1);
    check("len0_reads", addr_n - a0, 0);
    check("len0_writes", wr_n - w0, 0);

    // start while busy is ignored
    a0 = addr_n; d0 = data_n; w0 = wr_n; dn0 = done_n;
    start(1'b0, 6'h20, 7'd4);
    start(1'b1, 6'h30, 7'd2);
    wait_done("ign", dn0);
    check("ign_reads", addr_n - a0, 4);
    check("ign_last_adr", addr_log[a0+3], 'h23);
    check("ign_writes", wr_n - w0, 0);
    check("ign_last_data", data_log[d0+3], 'h63);

    // reset with three reads in flight
    lat = 3;
    a0 = addr_n; dn0 = done_n; k = 0;
    start(1'b0, 6'h00, 7'd8);
    while (addr_n - a0 < 3 && k < 50) begin
      tick();
      k++;
    end
    check("rst3_issued", addr_n - a0, 3);
    rst_i = 1'b1;
    tick();
    check("rst3_read", read, 0);
    check("rst3_sovalid", so_valid, 0);
    check("rst3_busy", busy, 0);
    rst_i = 1'b0;
    d1 = data_n;
    repeat (6) tick();
    check("rst3_late_rdv", data_n - d1, 0);
    check("rst3_nodone", done_n - dn0, 0);
    lat = 1;
    a0 = addr_n; d0 = data_n; dn0 = done_n;
    start(1'b0, 6'h05, 7'd4);
    wait_done("post", dn0);
    check("post_ndata", data_n - d0, 4);
    for (int i = 0; i < 4; i++) check("post_data", data_log[d0+i], 'h45 + i);

`ifdef BEL_AVL_MST_BITREV_EN
    cmd_bitrev = 1'b1;
    a0 = addr_n; dn0 = done_n;
    start(1'b0, 6'h00, 7'd64);
    cmd_bitrev = 1'b0;
    wait_done("brev", dn0);
    check("brev_adr0", addr_log[a0+0], 0);
    check("brev_adr1", addr_log[a0+1], 32);
    check("brev_adr2", addr_log[a0+2], 16);
    check("brev_adr3", addr_log[a0+3], 48);
    check("brev_adr4", addr_log[a0+4], 8);
    check("brev_adr63", addr_log[a0+63], 63);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
